// File: rtl/dmx_pkg.sv
// Shared types and constants for the DMX512 frame transmitter.
// The state encoding and slot geometry are used by the top and the bench-facing ports.
package dmx_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BREAK,
      MAB,
      SLOT
   } dmx_state_t;

   localparam int SLOT_BITS = 11;
   localparam int DMX_BAUD  = 250000;
   localparam int ADDR_W    = 9;

endpackage

// File: rtl/dmx_bit_timer.sv
// Divide-by-CLK_PER_BIT bit timer: counts 0..CLK_PER_BIT-1 and pulses tick on the last count.
// While clear is high the count is held at zero so the next bit starts on a clean boundary.
module dmx_bit_timer #(
   parameter int CLK_PER_BIT = 192
) (
   input  logic int_osc,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int CW = $clog2(CLK_PER_BIT);

   logic [CW-1:0] cnt_reg;

   assign tick = !clear && (cnt_reg == CW'(CLK_PER_BIT - 1));

   always_ff @(posedge int_osc or negedge reset) begin
      if (!reset) begin
         cnt_reg <= '0;
      end else if (clear || tick) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + CW'(1);
      end
   end

endmodule

// File: rtl/dmx_frame_tx.sv
// DMX512 frame transmitter: on each SPIDone rising edge sends break, MAB, start code and
// NUM_SLOTS buffer bytes at one bit per CLK_PER_BIT clocks, reading the channel buffer itself.
module dmx_frame_tx
   import dmx_pkg::*;
#(
   parameter int         CLK_PER_BIT = 192,
   parameter int         BREAK_BITS  = 25,
   parameter int         MAB_BITS    = 3,
   parameter int         NUM_SLOTS   = 512,
   parameter logic [7:0] START_CODE  = 8'h00
) (
   input  logic              int_osc,
   input  logic              reset,
   input  logic              SPIDone,
   input  logic [7:0]        chData,
   output logic [ADDR_W-1:0] chAddr,
   output logic              dmxOut,
   output logic              busy,
   output logic              frameDone
);

   localparam int PHASE_W = $clog2(BREAK_BITS + MAB_BITS + SLOT_BITS + 1);

   dmx_state_t        state_reg, state_next;
   logic [PHASE_W-1:0] bit_cnt_reg, bit_cnt_next;
   logic [9:0]         slot_cnt_reg, slot_cnt_next;
   logic [7:0]         shift_reg, shift_next;
   logic [ADDR_W-1:0]  addr_reg, addr_next;
   logic               pending_reg, pending_next;
   logic               spi_done_q_reg;
   logic               frame_done_reg, frame_done_next;
   logic               tick;
   logic               request;
   logic               start;
   logic               dmx_out_c;

   dmx_bit_timer #(
      .CLK_PER_BIT(CLK_PER_BIT)
   ) u_bit_timer (
      .int_osc(int_osc),
      .reset  (reset),
      .clear  (state_reg == IDLE),
      .tick   (tick)
   );

   assign request = SPIDone & ~spi_done_q_reg;
   // Holding off for the frameDone cycle guarantees an idle-high gap between frames.
   assign start   = (request | pending_reg) & ~frame_done_reg & (state_reg == IDLE);

   always_ff @(posedge int_osc or negedge reset) begin
      if (!reset) begin
         state_reg      <= IDLE;
         bit_cnt_reg    <= '0;
         slot_cnt_reg   <= '0;
         shift_reg      <= '0;
         addr_reg       <= '0;
         pending_reg    <= 1'b0;
         spi_done_q_reg <= 1'b0;
         frame_done_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         bit_cnt_reg    <= bit_cnt_next;
         slot_cnt_reg   <= slot_cnt_next;
         shift_reg      <= shift_next;
         addr_reg       <= addr_next;
         pending_reg    <= pending_next;
         spi_done_q_reg <= SPIDone;
         frame_done_reg <= frame_done_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      bit_cnt_next    = bit_cnt_reg;
      slot_cnt_next   = slot_cnt_reg;
      shift_next      = shift_reg;
      addr_next       = addr_reg;
      frame_done_next = 1'b0;

      if (start) begin
         pending_next = 1'b0;
      end else if (request) begin
         pending_next = 1'b1;
      end else begin
         pending_next = pending_reg;
      end

      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next   = BREAK;
               bit_cnt_next = '0;
            end
         end
         BREAK: begin
            if (tick) begin
               if (bit_cnt_reg == PHASE_W'(BREAK_BITS - 1)) begin
                  state_next   = MAB;
                  bit_cnt_next = '0;
                  addr_next    = '0;
               end else begin
                  bit_cnt_next = bit_cnt_reg + PHASE_W'(1);
               end
            end
         end
         MAB: begin
            if (tick) begin
               if (bit_cnt_reg == PHASE_W'(MAB_BITS - 1)) begin
                  state_next    = SLOT;
                  bit_cnt_next  = '0;
                  slot_cnt_next = '0;
                  shift_next    = START_CODE;
               end else begin
                  bit_cnt_next = bit_cnt_reg + PHASE_W'(1);
               end
            end
         end
         SLOT: begin
            if (tick) begin
               if (bit_cnt_reg == PHASE_W'(SLOT_BITS - 1)) begin
                  bit_cnt_next = '0;
                  if (slot_cnt_reg == 10'(NUM_SLOTS)) begin
                     state_next      = IDLE;
                     slot_cnt_next   = '0;
                     addr_next       = '0;
                     frame_done_next = 1'b1;
                  end else begin
                     slot_cnt_next = slot_cnt_reg + 10'd1;
                     shift_next    = chData;
                  end
               end else begin
                  bit_cnt_next = bit_cnt_reg + PHASE_W'(1);
                  if (bit_cnt_reg >= PHASE_W'(1) && bit_cnt_reg <= PHASE_W'(8)) begin
                     shift_next = {1'b0, shift_reg[7:1]};
                  end
                  // Entering the first stop bit: present the next slot's buffer index.
                  if (bit_cnt_reg == PHASE_W'(8) && slot_cnt_reg < 10'(NUM_SLOTS)) begin
                     addr_next = slot_cnt_reg[ADDR_W-1:0];
                  end
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Line level comes straight from reset-cleared state, so reset forces it high at once.
   always_comb begin
      dmx_out_c = 1'b1;
      case (state_reg)
         BREAK: dmx_out_c = 1'b0;
         SLOT: begin
            if (bit_cnt_reg == '0) begin
               dmx_out_c = 1'b0;
            end else if (bit_cnt_reg <= PHASE_W'(8)) begin
               dmx_out_c = shift_reg[0];
            end else begin
               dmx_out_c = 1'b1;
            end
         end
         default: dmx_out_c = 1'b1;
      endcase
   end

   assign dmxOut    = dmx_out_c;
   assign busy      = (state_reg != IDLE);
   assign frameDone = frame_done_reg;
   assign chAddr    = addr_reg;

endmodule

// File: tb/tb_dmx_frame_tx.sv
// Self-checking bench for dmx_frame_tx: compares the serial line, busy, frameDone and the
// buffer address stream against a frame waveform built from the DMX slot rules.
module tb_dmx_frame_tx;

   localparam int         CPB       = 4;
   localparam int         BRK       = 25;
   localparam int         MABB      = 3;
   localparam int         NS        = 3;
   localparam logic [7:0] SC        = 8'h00;
   localparam int         FRAME_LEN = (BRK + MABB + 11 * (NS + 1)) * CPB;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       spi_done = 1'b0;
   logic [7:0] ch_data = 8'h00;
   logic [8:0] ch_addr;
   logic       dmx_out;
   logic       busy;
   logic       frame_done;
   logic [7:0] mem [NS];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   always @(posedge clk) ch_data <= (int'(ch_addr) < NS) ? mem[ch_addr[1:0]] : 8'h00;

   dmx_frame_tx #(
      .CLK_PER_BIT(CPB),
      .BREAK_BITS (BRK),
      .MAB_BITS   (MABB),
      .NUM_SLOTS  (NS),
      .START_CODE (SC)
   ) dut (
      .int_osc  (clk),
      .reset    (rst_n),
      .SPIDone  (spi_done),
      .chData   (ch_data),
      .chAddr   (ch_addr),
      .dmxOut   (dmx_out),
      .busy     (busy),
      .frameDone(frame_done)
   );

   // Called at the negedge of the first expected break cycle; returns at the frameDone negedge.
   task automatic check_frame(input string tag);
      logic       exp_bits[$];
      int         addr_seq[$];
      logic [8:0] last_addr;
      logic [7:0] slot_byte;
      logic [10:0] word;
      for (int i = 0; i < BRK * CPB; i++) exp_bits.push_back(1'b0);
      for (int i = 0; i < MABB * CPB; i++) exp_bits.push_back(1'b1);
      for (int s = 0; s <= NS; s++) begin
         slot_byte = (s == 0) ? SC : mem[s-1];
         word = {2'b11, slot_byte, 1'b0};
         for (int b = 0; b < 11; b++)
            for (int c = 0; c < CPB; c++) exp_bits.push_back(word[b]);
      end
      last_addr = ch_addr;
      for (int i = 0; i <= FRAME_LEN; i++) begin
         if (ch_addr !== last_addr) begin
            addr_seq.push_back(int'(ch_addr));
            last_addr = ch_addr;
         end
         n_vec++;
         if (i < FRAME_LEN) begin
            if ({dmx_out, busy, frame_done} !== {exp_bits[i], 2'b10}) begin
               n_err++;
               $display("FAIL %s cycle %0d: dmxOut/busy/frameDone=%b%b%b expected %b10",
                        tag, i, dmx_out, busy, frame_done, exp_bits[i]);
            end
            @(negedge clk);
         end else if ({dmx_out, busy, frame_done, ch_addr} !== {3'b101, 9'd0}) begin
            n_err++;
            $display("FAIL %s_end: dmxOut/busy/frameDone=%b%b%b chAddr=%0d expected 101 chAddr=0",
                     tag, dmx_out, busy, frame_done, ch_addr);
         end
      end
      n_vec++;
      if (addr_seq.size() != 3 || addr_seq[0] != 1 || addr_seq[1] != 2 || addr_seq[2] != 0) begin
         n_err++;
         $display("FAIL %s_addr_seq: chAddr changes %p expected '{1,2,0}", tag, addr_seq);
      end
   endtask

   task automatic wait_idle(input int cycles, input string tag);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         n_vec++;
         if ({dmx_out, busy, frame_done} !== 3'b100) begin
            n_err++;
            $display("FAIL %s cycle %0d: dmxOut/busy/frameDone=%b%b%b expected 100",
                     tag, i, dmx_out, busy, frame_done);
         end
      end
   endtask

   task automatic randomize_mem();
      for (int i = 0; i < NS; i++) mem[i] = 8'($urandom_range(0, 255));
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_vec++;
      if ({dmx_out, busy, frame_done, ch_addr} !== {3'b100, 9'd0}) begin
         n_err++;
         $display("FAIL reset_state: dmxOut/busy/frameDone=%b%b%b chAddr=%0d expected 100 chAddr=0",
                  dmx_out, busy, frame_done, ch_addr);
      end
      rst_n = 1'b1;
      wait_idle(10, "reset_release_idle");
   endtask

   task automatic test_single_frame();
      mem[0] = 8'hA5;
      mem[1] = 8'h3C;
      mem[2] = 8'hFF;
      spi_done = 1'b1;
      fork
         begin
            repeat (20) @(negedge clk);
            spi_done = 1'b0;
         end
      join_none
      @(negedge clk);
      check_frame("single");
      wait_idle(300, "single_no_retrigger");
   endtask

   task automatic test_back_to_back();
      randomize_mem();
      spi_done = 1'b1;
      fork
         begin
            repeat (3) @(negedge clk);
            spi_done = 1'b0;
            repeat (200) @(negedge clk);
            spi_done = 1'b1;
            repeat (4) @(negedge clk);
            spi_done = 1'b0;
            repeat (20) @(negedge clk);
            spi_done = 1'b1;
            repeat (4) @(negedge clk);
            spi_done = 1'b0;
         end
      join_none
      @(negedge clk);
      check_frame("b2b_first");
      @(negedge clk);
      n_vec++;
      if ({dmx_out, busy} !== 2'b10) begin
         n_err++;
         $display("FAIL b2b_gap: dmxOut/busy=%b%b expected 10", dmx_out, busy);
      end
      @(negedge clk);
      check_frame("b2b_second");
      wait_idle(300, "b2b_no_third");
   endtask

   task automatic test_buffer_change();
      for (int k = 0; k < 3; k++) begin
         randomize_mem();
         wait_idle($urandom_range(1, 20), "change_gap");
         spi_done = 1'b1;
         fork
            begin
               automatic int wl = $urandom_range(1, 30);
               repeat (wl) @(negedge clk);
               spi_done = 1'b0;
            end
         join_none
         @(negedge clk);
         check_frame($sformatf("change%0d", k));
      end
      wait_idle(40, "change_tail");
   endtask

   task automatic test_held_high();
      randomize_mem();
      spi_done = 1'b1;
      @(negedge clk);
      check_frame("held");
      wait_idle(FRAME_LEN + 50, "held_no_retrigger");
      spi_done = 1'b0;
      wait_idle(10, "held_release");
   endtask

   task automatic test_reset_mid();
      randomize_mem();
      spi_done = 1'b1;
      @(negedge clk);
      spi_done = 1'b0;
      repeat ($urandom_range(120, 280)) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if ({dmx_out, busy, frame_done, ch_addr} !== {3'b100, 9'd0}) begin
         n_err++;
         $display("FAIL reset_mid_async: dmxOut/busy/frameDone=%b%b%b chAddr=%0d expected 100 chAddr=0",
                  dmx_out, busy, frame_done, ch_addr);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_idle(350, "post_reset_quiet");
   endtask

   initial begin
      for (int i = 0; i < NS; i++) mem[i] = 8'h00;
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_buffer_change();
      test_held_high();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
